// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with occupancy count, replace-top, clear and sticky error flags.
// Optional peek read port enabled by defining PARAM_STACK_PEEK_EN.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
`ifdef PARAM_STACK_PEEK_EN
    ,
    input  logic [CW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;
    logic             d_valid_reg, d_valid_next;
    logic [WIDTH-1:0] d_out_reg;
    logic             wr_en, rd_en;
    logic [AW-1:0]    wr_addr, top_addr;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign top_addr = AW'(count_reg - CW'(1));

    always_comb begin
        count_next   = count_reg;
        ovf_next     = ovf_reg;
        udf_next     = udf_reg;
        d_valid_next = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        wr_addr      = AW'(count_reg);
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
            udf_next   = 1'b0;
        end else if (push && pop) begin
            // Replace-top on a non-empty stack; on an empty stack it degrades to a plain push.
            wr_en = 1'b1;
            if (!empty) begin
                wr_addr      = top_addr;
                rd_en        = 1'b1;
                d_valid_next = 1'b1;
            end else begin
                count_next = count_reg + CW'(1);
            end
        end else if (push) begin
            if (!full) begin
                wr_en      = 1'b1;
                count_next = count_reg + CW'(1);
            end else begin
                ovf_next = 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                rd_en        = 1'b1;
                d_valid_next = 1'b1;
                count_next   = count_reg - CW'(1);
            end else begin
                udf_next = 1'b1;
            end
        end else if (tos) begin
            if (!empty) begin
                rd_en        = 1'b1;
                d_valid_next = 1'b1;
            end else begin
                udf_next = 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
            udf_reg     <= 1'b0;
            d_valid_reg <= 1'b0;
            d_out_reg   <= '0;
        end else begin
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
            udf_reg     <= udf_next;
            d_valid_reg <= d_valid_next;
            if (rd_en) begin
                d_out_reg <= mem[top_addr];
            end
        end
    end

    assign count   = count_reg;
    assign ovf     = ovf_reg;
    assign udf     = udf_reg;
    assign d_valid = d_valid_reg;
    assign d_out   = d_out_reg;

`ifdef PARAM_STACK_PEEK_EN
    logic [AW-1:0]    peek_addr;
    logic [WIDTH-1:0] peek_data_reg;

    assign peek_addr = AW'(count_reg - CW'(1) - peek_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peek_data_reg <= '0;
        end else if (peek_idx < count_reg) begin
            peek_data_reg <= mem[peek_addr];
        end else begin
            peek_data_reg <= '0;
        end
    end

    assign peek_data = peek_data_reg;
`else
    // Core-only build: no peek port or read path.
`endif

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: a queue-based LIFO model predicts each cycle's outputs,
// a monitor compares them one cycle later. Peek checks run when PARAM_STACK_PEEK_EN is defined.
module tb_param_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk, rst, push, pop, tos, clr;
    logic [WIDTH-1:0] d_in, d_out;
    logic             d_valid, empty, full, ovf, udf;
    logic [CW-1:0]    count;
`ifdef PARAM_STACK_PEEK_EN
    logic [CW-1:0]    peek_idx;
    logic [WIDTH-1:0] peek_data;
    int               next_peek = 0;
`endif

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .clr(clr),
        .d_in(d_in), .d_out(d_out), .d_valid(d_valid), .count(count),
        .empty(empty), .full(full), .ovf(ovf), .udf(udf)
`ifdef PARAM_STACK_PEEK_EN
        , .peek_idx(peek_idx), .peek_data(peek_data)
`endif
    );

    typedef struct {
        int               cnt;
        bit               ovf;
        bit               udf;
        bit               dv;
        logic [WIDTH-1:0] dout;
        logic [WIDTH-1:0] peek;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf, m_udf;
    int               checks = 0;
    int               errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Drive one cycle of stimulus and queue the state the stack must show after the edge.
    task automatic step(input bit pu, input bit po, input bit t, input bit c, input logic [WIDTH-1:0] di);
        exp_t e;
        bit   dv;
        @(negedge clk);
        push = pu; pop = po; tos = t; clr = c; d_in = di;
        e.peek = '0;
`ifdef PARAM_STACK_PEEK_EN
        peek_idx = CW'(next_peek);
        if (next_peek < stk.size()) e.peek = stk[stk.size() - 1 - next_peek];
`endif
        dv = 1'b0;
        if (c) begin
            stk.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (pu && po) begin
            if (stk.size() > 0) begin
                m_dout = stk[stk.size() - 1];
                stk[stk.size() - 1] = di;
                dv = 1'b1;
            end else begin
                stk.push_back(di);
            end
        end else if (pu) begin
            if (stk.size() < DEPTH) stk.push_back(di);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (stk.size() > 0) begin
                m_dout = stk.pop_back();
                dv = 1'b1;
            end else m_udf = 1'b1;
        end else if (t) begin
            if (stk.size() > 0) begin
                m_dout = stk[stk.size() - 1];
                dv = 1'b1;
            end else m_udf = 1'b1;
        end
        e.cnt  = stk.size();
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        e.dv   = dv;
        e.dout = m_dout;
        exp_q.push_back(e);
        $display("step push=%0b pop=%0b tos=%0b clr=%0b d_in=%02h -> cnt=%0d dv=%0b dout=%02h",
                 pu, po, t, c, di, e.cnt, dv, m_dout);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_dout"}, 32'(d_out), 0);
        chk({tag, "_dvalid"}, 32'(d_valid), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_ovf"}, 32'(ovf), 0);
        chk({tag, "_udf"}, 32'(udf), 0);
    endtask

    // Reset pulse entirely between two clock edges; effect must be immediate.
    task automatic mid_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_state("async_rst");
        model_reset();
        #1 rst = 1'b1;
        $display("async reset pulse applied");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", 32'(count), 32'(e.cnt));
                chk("empty", 32'(empty), 32'(e.cnt == 0));
                chk("full", 32'(full), 32'(e.cnt == DEPTH));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("udf", 32'(udf), 32'(e.udf));
                chk("d_valid", 32'(d_valid), 32'(e.dv));
                chk("d_out", 32'(d_out), 32'(e.dout));
`ifdef PARAM_STACK_PEEK_EN
                chk("peek_data", 32'(peek_data), 32'(e.peek));
`endif
            end else if (d_valid) begin
                chk("spurious_valid", 32'(d_valid), 0);
            end
        end
    end

    initial begin : stimulus
        int w;
        rst = 1'b0; push = 0; pop = 0; tos = 0; clr = 0; d_in = '0;
`ifdef PARAM_STACK_PEEK_EN
        peek_idx = '0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;

        // Fill, overflow, pop.
        step(1, 0, 0, 0, 8'h11); step(1, 0, 0, 0, 8'h22);
        step(1, 0, 0, 0, 8'h33); step(1, 0, 0, 0, 8'h44);
        step(1, 0, 0, 0, 8'h55); step(0, 1, 0, 0, 8'h00);

        // Underflow from empty, then clear.
        mid_reset();
        step(0, 1, 0, 0, 8'h00); step(0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);

        // tos then two pops.
        step(1, 0, 0, 0, 8'hA1); step(1, 0, 0, 0, 8'hB2);
        step(0, 0, 1, 0, 8'h00); step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);

        // Replace-top on a full stack, and push+pop on an empty stack.
        step(1, 1, 0, 0, 8'h5A); step(0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h11); step(1, 0, 0, 0, 8'h22);
        step(1, 0, 0, 0, 8'h33); step(1, 0, 0, 0, 8'h44);
        step(1, 1, 0, 0, 8'h99); step(0, 1, 0, 0, 8'h00);

        // Asynchronous reset with contents, then reuse.
        step(0, 0, 0, 1, 8'h00);
        step(1, 0, 0, 0, 8'h01); step(1, 0, 0, 0, 8'h02);
        step(1, 0, 0, 0, 8'h03);
        mid_reset();
        step(1, 0, 0, 0, 8'h07); step(0, 1, 0, 0, 8'h00);

`ifdef PARAM_STACK_PEEK_EN
        step(1, 0, 0, 0, 8'h11); step(1, 0, 0, 0, 8'h22);
        step(1, 0, 0, 0, 8'h33);
        for (int i = 0; i < 4; i++) begin
            next_peek = i;
            step(0, 0, 0, 0, 8'h00);
        end
`endif

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
`ifdef PARAM_STACK_PEEK_EN
            next_peek = int'($urandom_range(0, DEPTH));
`endif
            if (r < 3) step(0, 0, 0, 1, 8'h00);
            else if (r < 40) step(1, 0, 0, 0, 8'($urandom));
            else if (r < 55) step(1, 1, 0, 0, 8'($urandom));
            else if (r < 80) step(0, 1, 0, 0, 8'($urandom));
            else if (r < 92) step(0, 0, 1, 0, 8'($urandom));
            else step(0, 0, 0, 0, 8'($urandom));
        end

        @(negedge clk);
        push = 0; pop = 0; tos = 0; clr = 0;
        w = 0;
        while (exp_q.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
